// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  // Low bit of element idx inside a flat bus of equal-width elements.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write port bundle of the register file; master = issue/writeback side.
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 6,
  parameter int NR    = 4,
  parameter int NW    = 6
);
  logic                ready;
  logic [NR-1:0]       rd_en;
  logic [NR*AW-1:0]    rd_addr;
  logic [NR*WIDTH-1:0] rd_data;
  logic [NR-1:0]       rd_valid;
  logic [NW-1:0]       wr_en;
  logic [NW*AW-1:0]    wr_addr;
  logic [NW*WIDTH-1:0] wr_data;
  logic                wr_conflict;

  modport master (
    input  ready, rd_data, rd_valid, wr_conflict,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output ready, rd_data, rd_valid, wr_conflict,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// Write resolver: per-address winning enable/data, highest port wins, plus collision flag.
// Purely combinational; no backpressure.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int NW       = 6,
  parameter int ZERO_REG = 0
) (
  input  logic [NW-1:0]               wr_en,
  input  logic [NW*AW-1:0]            wr_addr,
  input  logic [NW*WIDTH-1:0]         wr_data,
  output logic [DEPTH-1:0]            wen,
  output logic [DEPTH-1:0][WIDTH-1:0] wdat,
  output logic                        conflict
);

  logic [NW-1:0] eff;

  // Writes to the hardwired zero register vanish before arbitration.
  always_comb begin
    eff = '0;
    for (int j = 0; j < NW; j++) begin
      eff[j] = wr_en[j] && !(ZERO_REG != 0 && wr_addr[slice_lo(j, AW) +: AW] == '0);
    end
  end

  always_comb begin
    wen      = '0;
    wdat     = '0;
    conflict = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int j = 0; j < NW; j++) begin
        if (eff[j] && wr_addr[slice_lo(j, AW) +: AW] == AW'(a)) begin
          if (wen[a]) conflict = 1'b1;
          wen[a]  = 1'b1;
          wdat[a] = wr_data[slice_lo(j, WIDTH) +: WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// NR-read / NW-write register file with self-initialisation after reset.
// Reads: 1-cycle latency with write-first bypass; no backpressure, ready gates usage.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 64,
  parameter int NR        = 4,
  parameter int NW        = 6,
  parameter int ZERO_REG  = 0,
  parameter int INIT_MODE = INIT_INDEX
) (
  input  logic        clk,
  input  logic        rstn,
  regfile_mp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LAST = DEPTH[AW:0] - 1'b1;

  rf_state_t                 state;
  logic [AW:0]               cnt;
  logic [WIDTH-1:0]          mem [DEPTH];
  logic [NR-1:0][WIDTH-1:0]  rd_q;
  logic [NR-1:0][WIDTH-1:0]  rd_next;
  logic [NR-1:0]             rd_vld_q;
  logic                      ready_q;
  logic                      conflict_q;
  logic [AW-1:0]             ra [NR];
  logic [NW-1:0]             wr_en_run;
  logic [DEPTH-1:0]          arb_wen;
  logic [DEPTH-1:0][WIDTH-1:0] arb_wdat;
  logic                      arb_conflict;
  logic [WIDTH-1:0]          init_val;

  assign wr_en_run = (state == RF_RUN) ? bus.wr_en : '0;
  assign init_val  = (INIT_MODE == INIT_ZERO) ? '0 : WIDTH'(cnt);

  regfile_wr_arb #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_arb (
    .wr_en    (wr_en_run),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .wen      (arb_wen),
    .wdat     (arb_wdat),
    .conflict (arb_conflict)
  );

  for (genvar k = 0; k < NR; k++) begin : g_ra
    assign ra[k] = bus.rd_addr[slice_lo(k, AW) +: AW];
  end

  // Same-edge writes take precedence over stored contents.
  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NR; k++) begin
      if (ZERO_REG != 0 && ra[k] == '0) rd_next[k] = '0;
      else if (arb_wen[ra[k]])          rd_next[k] = arb_wdat[ra[k]];
      else                              rd_next[k] = mem[ra[k]];
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      if (state == RF_INIT) begin
        mem[cnt[AW-1:0]] <= init_val;
      end else begin
        for (int a = 0; a < DEPTH; a++) begin
          if (arb_wen[a]) mem[a] <= arb_wdat[a];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= RF_INIT;
      cnt        <= '0;
      ready_q    <= 1'b0;
      conflict_q <= 1'b0;
      rd_vld_q   <= '0;
      rd_q       <= '0;
    end else begin
      case (state)
        RF_INIT: begin
          cnt        <= cnt + 1'b1;
          rd_vld_q   <= '0;
          conflict_q <= 1'b0;
          if (cnt == LAST) begin
            state   <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        RF_RUN: begin
          conflict_q <= arb_conflict;
          for (int k = 0; k < NR; k++) begin
            rd_vld_q[k] <= bus.rd_en[k];
            if (bus.rd_en[k]) rd_q[k] <= rd_next[k];
          end
        end
        default: state <= RF_INIT;
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.rd_data     = rd_q;
  assign bus.rd_valid    = rd_vld_q;
  assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default config against a behavioural model, plus zero-reg and small configs.
module tb_regfile_mp;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(32), .AW(6), .NR(4), .NW(6)) b0 ();
  regfile_mp_if #(.WIDTH(16), .AW(3), .NR(2), .NW(2)) b1 ();
  regfile_mp_if #(.WIDTH(8),  .AW(4), .NR(2), .NW(2)) b2 ();

  regfile_mp u0 (.clk(clk), .rstn(rstn), .bus(b0));

  regfile_mp #(.WIDTH(16), .DEPTH(8), .NR(2), .NW(2), .ZERO_REG(1), .INIT_MODE(1))
    u1 (.clk(clk), .rstn(rstn), .bus(b1));

  regfile_mp #(.WIDTH(8), .DEPTH(16), .NR(2), .NW(2), .ZERO_REG(0), .INIT_MODE(0))
    u2 (.clk(clk), .rstn(rstn), .bus(b2));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model of the default instance: a plain array, init counter and write-then-read.
  logic [31:0] m_mem [64];
  logic [31:0] m_data [4];
  logic [3:0]  m_valid;
  logic        m_ready;
  logic        m_conf;
  logic        m_live = 1'b0;
  int          m_done;

  always @(posedge clk) begin : model
    logic [31:0] nmem [64];
    int          hits [64];
    logic        conf;
    if (!rstn) begin
      m_live  <= 1'b1;
      m_ready <= 1'b0;
      m_conf  <= 1'b0;
      m_valid <= '0;
      m_done  <= 0;
      for (int k = 0; k < 4; k++) m_data[k] <= '0;
    end else if (m_done < 64) begin
      m_mem[m_done] <= 32'(m_done);
      m_done        <= m_done + 1;
      m_ready       <= (m_done + 1 == 64);
      m_valid       <= '0;
      m_conf        <= 1'b0;
    end else begin
      conf = 1'b0;
      for (int a = 0; a < 64; a++) begin
        nmem[a] = m_mem[a];
        hits[a] = 0;
      end
      for (int j = 0; j < 6; j++) begin
        if (b0.wr_en[j]) begin
          nmem[b0.wr_addr[j*6 +: 6]] = b0.wr_data[j*32 +: 32];
          hits[b0.wr_addr[j*6 +: 6]]++;
        end
      end
      for (int a = 0; a < 64; a++) if (hits[a] > 1) conf = 1'b1;
      for (int k = 0; k < 4; k++) begin
        m_valid[k] <= b0.rd_en[k];
        if (b0.rd_en[k]) m_data[k] <= nmem[b0.rd_addr[k*6 +: 6]];
      end
      for (int a = 0; a < 64; a++) m_mem[a] <= nmem[a];
      m_conf <= conf;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("cmp_ready", b0.ready, m_ready);
      chk("cmp_conflict", b0.wr_conflict, m_conf);
      for (int k = 0; k < 4; k++) begin
        chk("cmp_rd_valid", b0.rd_valid[k], m_valid[k]);
        chk("cmp_rd_data", b0.rd_data[k*32 +: 32], m_data[k]);
      end
    end
  end

  task automatic idle0();
    b0.rd_en = '0;
    b0.wr_en = '0;
  endtask

  task automatic rd0(input int k, input logic [5:0] a);
    b0.rd_en[k]          = 1'b1;
    b0.rd_addr[k*6 +: 6] = a;
  endtask

  task automatic wr0(input int j, input logic [5:0] a, input logic [31:0] d);
    b0.wr_en[j]            = 1'b1;
    b0.wr_addr[j*6 +: 6]   = a;
    b0.wr_data[j*32 +: 32] = d;
  endtask

  initial begin
    int first0, first1, first2;
    b0.rd_en = '0; b0.rd_addr = '0; b0.wr_en = '0; b0.wr_addr = '0; b0.wr_data = '0;
    b1.rd_en = '0; b1.rd_addr = '0; b1.wr_en = '0; b1.wr_addr = '0; b1.wr_data = '0;
    b2.rd_en = '0; b2.rd_addr = '0; b2.wr_en = '0; b2.wr_addr = '0; b2.wr_data = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", b0.ready, 0);
    chk("rst_valid", b0.rd_valid, 0);
    chk("rst_data", 32'(|b0.rd_data), 0);
    chk("rst_conflict", b0.wr_conflict, 0);

    // First release: the small instances finish, then reset lands mid-INIT of the big one.
    rstn   = 1'b1;
    first1 = 0;
    first2 = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i >= 5 && i <= 10) b0.rd_en = '1; else idle0();
      @(negedge clk);
      if (b1.ready && first1 == 0) first1 = i;
      if (b2.ready && first2 == 0) first2 = i;
      chk("init_rd_valid", b0.rd_valid, 0);
    end
    chk("first_lat1", first1, 8);
    chk("first_lat2", first2, 16);
    chk("mid_init_ready0", b0.ready, 0);

    idle0();
    rstn = 1'b0;
    @(negedge clk);
    chk("rerst_ready1", b1.ready, 0);
    rstn   = 1'b1;
    first0 = 0;
    first1 = 0;
    first2 = 0;
    for (int i = 1; i <= 70; i++) begin
      idle0();
      if (i >= 5 && i <= 10) begin
        rd0(0, 6'd1);
        rd0(1, 6'd2);
        wr0(0, 6'd2, 32'hBAD0BAD0);
      end
      @(negedge clk);
      if (b0.ready && first0 == 0) first0 = i;
      if (b1.ready && first1 == 0) first1 = i;
      if (b2.ready && first2 == 0) first2 = i;
    end
    chk("ready_lat0", first0, 64);
    chk("ready_lat1", first1, 8);
    chk("ready_lat2", first2, 16);

    // Index-filled contents.
    idle0(); rd0(0, 6'd0); rd0(1, 6'd5); rd0(2, 6'd63);
    @(negedge clk);
    chk("rd_valid_012", b0.rd_valid, 4'b0111);
    chk("rd_addr0", b0.rd_data[31:0], 32'd0);
    chk("rd_addr5", b0.rd_data[63:32], 32'd5);
    chk("rd_addr63", b0.rd_data[95:64], 32'd63);
    idle0();
    @(negedge clk);
    chk("rd_valid_drop", b0.rd_valid, 4'b0000);
    chk("rd_hold", b0.rd_data[63:32], 32'd5);
    rd0(0, 6'd2);
    @(negedge clk);
    chk("init_wr_ignored", b0.rd_data[31:0], 32'd2);

    // Write-first bypass.
    idle0(); wr0(2, 6'd7, 32'hDEADBEEF); rd0(0, 6'd7);
    @(negedge clk);
    chk("bypass", b0.rd_data[31:0], 32'hDEADBEEF);
    idle0(); rd0(3, 6'd7);
    @(negedge clk);
    chk("reread", b0.rd_data[127:96], 32'hDEADBEEF);

    // Collisions: highest port wins, conflict is a single-cycle pulse.
    idle0(); wr0(1, 6'd10, 32'h11); wr0(4, 6'd10, 32'h44);
    @(negedge clk);
    chk("conflict_set", b0.wr_conflict, 1);
    idle0(); rd0(1, 6'd10);
    @(negedge clk);
    chk("conflict_pulse", b0.wr_conflict, 0);
    chk("prio_44", b0.rd_data[63:32], 32'h44);
    idle0(); wr0(0, 6'd10, 32'hA); wr0(5, 6'd10, 32'hB); rd0(2, 6'd10);
    @(negedge clk);
    chk("conflict_bypass", b0.wr_conflict, 1);
    chk("prio_bypass", b0.rd_data[95:64], 32'hB);

    // Six distinct-address writes.
    idle0();
    for (int j = 0; j < 6; j++) wr0(j, 6'(20 + j), 32'h1000 + 32'(j));
    @(negedge clk);
    chk("distinct_noconf", b0.wr_conflict, 0);
    idle0();
    for (int k = 0; k < 4; k++) rd0(k, 6'(20 + k));
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk("distinct_rd", b0.rd_data[k*32 +: 32], 32'h1000 + 32'(k));
    idle0(); rd0(0, 6'd24); rd0(1, 6'd25);
    @(negedge clk);
    chk("distinct_rd24", b0.rd_data[31:0], 32'h1004);
    chk("distinct_rd25", b0.rd_data[63:32], 32'h1005);
    chk("model_pin25", m_mem[25], 32'h1005);
    chk("model_pin7", m_mem[7], 32'hDEADBEEF);
    idle0();

    // Zero-register instance.
    b1.wr_en = 2'b01; b1.wr_addr = {3'd0, 3'd0}; b1.wr_data = {16'h0, 16'h1234};
    b1.rd_en = 2'b01; b1.rd_addr = {3'd0, 3'd0};
    @(negedge clk);
    chk("z_rd0", b1.rd_data[15:0], 0);
    chk("z_valid", b1.rd_valid, 2'b01);
    chk("z_conf_single", b1.wr_conflict, 0);
    b1.wr_en = 2'b11; b1.wr_addr = {3'd0, 3'd0}; b1.wr_data = {16'h5555, 16'h6666};
    b1.rd_en = 2'b10; b1.rd_addr = {3'd5, 3'd0};
    @(negedge clk);
    chk("z_conf_dual", b1.wr_conflict, 0);
    chk("z_rd5", b1.rd_data[31:16], 16'd5);
    b1.wr_en = 2'b11; b1.wr_addr = {3'd3, 3'd3}; b1.wr_data = {16'hBBBB, 16'hAAAA};
    b1.rd_en = 2'b01; b1.rd_addr = {3'd0, 3'd3};
    @(negedge clk);
    chk("z_conf_nonzero", b1.wr_conflict, 1);
    chk("z_bypass3", b1.rd_data[15:0], 16'hBBBB);
    b1.wr_en = 2'b00; b1.rd_en = 2'b11; b1.rd_addr = {3'd3, 3'd0};
    @(negedge clk);
    chk("z_rd0_after", b1.rd_data[15:0], 0);
    chk("z_rd3_after", b1.rd_data[31:16], 16'hBBBB);
    chk("z_conf_clear", b1.wr_conflict, 0);
    b1.rd_en = 2'b00;

    // Zero-filled small instance.
    for (int a = 0; a < 16; a += 2) begin
      b2.rd_en   = 2'b11;
      b2.rd_addr = {4'(a + 1), 4'(a)};
      @(negedge clk);
      chk("s_rd_even", b2.rd_data[7:0], 0);
      chk("s_rd_odd", b2.rd_data[15:8], 0);
    end
    b2.rd_en = 2'b00; b2.wr_en = 2'b01; b2.wr_addr = {4'd0, 4'd15}; b2.wr_data = {8'h00, 8'hFF};
    @(negedge clk);
    b2.wr_en = 2'b00; b2.rd_en = 2'b10; b2.rd_addr = {4'd15, 4'd0};
    @(negedge clk);
    chk("s_rd15", b2.rd_data[15:8], 8'hFF);
    chk("s_valid", b2.rd_valid, 2'b10);
    b2.rd_en = 2'b00;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
